// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: registered two-channel write-port controller for the
// register file. Channel A always wins; a losing channel B request waits in a
// one-entry hold buffer. Read bypass exposes writes not yet committed.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired, writes discarded).
module regfile_write_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned NREG = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              wr_ready_b,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [NREG-1:0]   wordline,
  output logic [DATA_W-1:0] wr_data_q,
  output logic              bypass_hit0,
  output logic              bypass_hit1,
  output logic [DATA_W-1:0] bypass_data0,
  output logic [DATA_W-1:0] bypass_data1,
  output logic              collision,
  output logic [7:0]        coll_cnt
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              stg_valid;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  logic              acc_a, acc_b;
  logic              drop_b, squash, to_hold, coll_ev;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;

  logic [ADDR_W-1:0]           rd_addr [2];
  logic [1:0]                  hit;
  logic [1:0][DATA_W-1:0]      hit_data;

  assign wr_ready_b = !hold_valid && !rst;

  // Acceptance, conflict detection and issue selection for this cycle
  always_comb begin
    acc_a   = !rst && wr_en_a && !(ZERO_REG && wr_addr_a == '0);
    acc_b   = wr_en_b && wr_ready_b && !(ZERO_REG && wr_addr_b == '0);
    drop_b  = acc_a && acc_b && (wr_addr_a == wr_addr_b);
    to_hold = acc_a && acc_b && (wr_addr_a != wr_addr_b);
    squash  = acc_a && hold_valid && (hold_addr == wr_addr_a);
    coll_ev = drop_b || squash;
    issue_valid = 1'b0;
    issue_addr  = '0;
    issue_data  = '0;
    if (acc_a) begin
      issue_valid = 1'b1;
      issue_addr  = wr_addr_a;
      issue_data  = wr_data_a;
    end else if (hold_valid) begin
      issue_valid = 1'b1;
      issue_addr  = hold_addr;
      issue_data  = hold_data;
    end else if (acc_b) begin
      issue_valid = 1'b1;
      issue_addr  = wr_addr_b;
      issue_data  = wr_data_b;
    end
  end

  // Stage register and its decoded wordline / data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      wordline  <= '0;
      wr_data_q <= '0;
    end else begin
      stg_valid <= issue_valid;
      stg_addr  <= issue_addr;
      stg_data  <= issue_data;
      wordline  <= issue_valid ? (NREG'(1) << issue_addr) : '0;
      wr_data_q <= issue_valid ? issue_data : '0;
    end
  end

  // Hold buffer: filled by a B request that lost to A, emptied on issue or squash
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (to_hold) begin
      hold_valid <= 1'b1;
      hold_addr  <= wr_addr_b;
      hold_data  <= wr_data_b;
    end else if (squash || (!acc_a && hold_valid)) begin
      hold_valid <= 1'b0;
    end
  end

  // Collision pulse and saturating collision counter
  always_ff @(posedge clk) begin
    if (rst) begin
      collision <= 1'b0;
      coll_cnt  <= '0;
    end else begin
      collision <= coll_ev;
      if (coll_ev && coll_cnt != 8'hFF) coll_cnt <= coll_cnt + 8'd1;
    end
  end

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;

  // Bypass lookup, newest source first: incoming A, incoming B, hold, stage.
  // Incoming writes are included so a read in the request cycle sees the data.
  always_comb begin
    hit      = '0;
    hit_data = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (ZERO_REG && rd_addr[k] == '0) begin
        hit[k] = 1'b0;
      end else if (acc_a && wr_addr_a == rd_addr[k]) begin
        hit[k]      = 1'b1;
        hit_data[k] = wr_data_a;
      end else if (acc_b && wr_addr_b == rd_addr[k]) begin
        hit[k]      = 1'b1;
        hit_data[k] = wr_data_b;
      end else if (hold_valid && hold_addr == rd_addr[k]) begin
        hit[k]      = 1'b1;
        hit_data[k] = hold_data;
      end else if (stg_valid && stg_addr == rd_addr[k]) begin
        hit[k]      = 1'b1;
        hit_data[k] = stg_data;
      end
    end
  end

  assign bypass_hit0  = hit[0];
  assign bypass_hit1  = hit[1];
  assign bypass_data0 = hit_data[0];
  assign bypass_data1 = hit_data[1];

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed plan scenarios followed by randomized
// traffic, checked against a behavioural model of the write controller.
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_a, wr_en_b;
  logic [3:0]  wr_addr_a, wr_addr_b, rd_addr0, rd_addr1;
  logic [15:0] wr_data_a, wr_data_b;
  logic        wr_ready_b;
  logic [15:0] wordline, wr_data_q;
  logic        bypass_hit0, bypass_hit1;
  logic [15:0] bypass_data0, bypass_data1;
  logic        collision;
  logic [7:0]  coll_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  regfile_write_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .wr_ready_b(wr_ready_b), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .wordline(wordline), .wr_data_q(wr_data_q),
    .bypass_hit0(bypass_hit0), .bypass_hit1(bypass_hit1),
    .bypass_data0(bypass_data0), .bypass_data1(bypass_data1),
    .collision(collision), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: pending writes in hold / stage, the latest accepted value per
  // register (shadow), and the collision counter.
  logic        m_hold_v, m_stg_v, m_coll;
  logic [3:0]  m_hold_addr, m_stg_addr;
  logic [15:0] m_hold_data, m_stg_data;
  int          m_cnt;
  logic [15:0] shadow [16];

  function automatic bit discarded(input logic [3:0] a);
    return ZR && (a == 4'd0);
  endfunction

  task automatic exp_bypass(input logic [3:0] r, input bit aa, input bit ab,
                            output bit h, output logic [15:0] d);
    h = 1'b0;
    d = 16'h0;
    if (discarded(r)) return;
    if (aa && wr_addr_a == r) begin h = 1'b1; d = wr_data_a; end
    else if (ab && wr_addr_b == r) begin h = 1'b1; d = wr_data_b; end
    else if ((m_hold_v && m_hold_addr == r) || (m_stg_v && m_stg_addr == r)) begin
      h = 1'b1;
      d = shadow[r];
    end
  endtask

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic step(input bit r, input bit ea, input logic [3:0] aa, input logic [15:0] da,
                      input bit eb, input logic [3:0] ab, input logic [15:0] db,
                      input logic [3:0] r0, input logic [3:0] r1);
    bit acc_a, acc_b, rdy, h;
    logic [15:0] d, exp_wl;
    rst = r; wr_en_a = ea; wr_addr_a = aa; wr_data_a = da;
    wr_en_b = eb; wr_addr_b = ab; wr_data_b = db;
    rd_addr0 = r0; rd_addr1 = r1;
    #1;
    rdy   = !m_hold_v && !r;
    acc_a = !r && ea && !discarded(aa);
    acc_b = eb && rdy && !discarded(ab);
    exp_wl = m_stg_v ? (16'd1 << m_stg_addr) : 16'h0;
    chk("wordline", 64'(wordline), 64'(exp_wl));
    chk("wr_data_q", 64'(wr_data_q), 64'(m_stg_v ? m_stg_data : 16'h0));
    chk("collision", 64'(collision), 64'(m_coll));
    chk("coll_cnt", 64'(coll_cnt), 64'(m_cnt));
    chk("wr_ready_b", 64'(wr_ready_b), 64'(rdy));
    exp_bypass(r0, acc_a, acc_b, h, d);
    chk("bypass_hit0", 64'(bypass_hit0), 64'(h));
    chk("bypass_data0", 64'(bypass_data0), 64'(d));
    exp_bypass(r1, acc_a, acc_b, h, d);
    chk("bypass_hit1", 64'(bypass_hit1), 64'(h));
    chk("bypass_data1", 64'(bypass_data1), 64'(d));
    @(posedge clk);
    if (r) begin
      m_hold_v = 0; m_stg_v = 0; m_coll = 0; m_cnt = 0;
    end else begin
      bit same  = acc_a && acc_b && (aa == ab);
      bit sq    = acc_a && m_hold_v && (m_hold_addr == aa);
      m_coll = same || sq;
      if (m_coll && m_cnt < 255) m_cnt++;
      if (acc_b && !same) shadow[ab] = db;
      if (acc_a) shadow[aa] = da;
      if (acc_a) begin
        m_stg_v = 1; m_stg_addr = aa; m_stg_data = da;
        if (acc_b && !same) begin
          m_hold_v = 1; m_hold_addr = ab; m_hold_data = db;
        end else if (sq) m_hold_v = 0;
      end else if (m_hold_v) begin
        m_stg_v = 1; m_stg_addr = m_hold_addr; m_stg_data = m_hold_data;
        m_hold_v = 0;
      end else if (acc_b) begin
        m_stg_v = 1; m_stg_addr = ab; m_stg_data = db;
      end else m_stg_v = 0;
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] r0);
    step(0, 0, 0, 0, 0, 0, 0, r0, 0);
  endtask

  initial begin
    m_hold_v = 0; m_stg_v = 0; m_coll = 0; m_cnt = 0;
    m_hold_addr = 0; m_hold_data = 0; m_stg_addr = 0; m_stg_data = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 16'h0;
    rst = 1; wr_en_a = 0; wr_en_b = 0; wr_addr_a = 0; wr_addr_b = 0;
    wr_data_a = 0; wr_data_b = 0; rd_addr0 = 0; rd_addr1 = 0;
    @(posedge clk); #1;

    // Reset with A requests present
    step(1, 1, 4'd3, 16'hDEAD, 0, 0, 0, 4'd3, 0);
    step(1, 1, 4'd3, 16'hDEAD, 0, 0, 0, 4'd3, 0);
    chk("rst_wordline", 64'(wordline), 64'h0);
    chk("rst_coll_cnt", 64'(coll_cnt), 64'h0);
    idle(0);
    chk("rst_release_ready", 64'(wr_ready_b), 64'h1);

    // Single A write with bypass in the request cycle
    step(0, 1, 4'hA, 16'h1234, 0, 0, 0, 4'hA, 0);
    chk("single_wl", 64'(wordline), 64'h0400);
    chk("single_data", 64'(wr_data_q), 64'h1234);
    idle(4'hA);
    chk("single_wl_clear", 64'(wordline), 64'h0);

    // Simultaneous A and B, different addresses
    step(0, 1, 4'd5, 16'h1111, 1, 4'd9, 16'h2222, 4'd9, 4'd5);
    chk("dual_wl_a", 64'(wordline), 64'h0020);
    chk("dual_ready_low", 64'(wr_ready_b), 64'h0);
    idle(4'd9);
    chk("dual_wl_b", 64'(wordline), 64'h0200);
    chk("dual_data_b", 64'(wr_data_q), 64'h2222);
    idle(0);
    chk("dual_ready_high", 64'(wr_ready_b), 64'h1);

    // Same-address A and B
    step(0, 1, 4'd7, 16'hAAAA, 1, 4'd7, 16'hBBBB, 4'd7, 0);
    chk("same_wl", 64'(wordline), 64'h0080);
    chk("same_data", 64'(wr_data_q), 64'hAAAA);
    chk("same_coll", 64'(collision), 64'h1);
    chk("same_cnt", 64'(coll_cnt), 64'h1);
    idle(4'd7);
    chk("same_no_second", 64'(wordline), 64'h0);
    chk("same_coll_pulse", 64'(collision), 64'h0);

    // Squash of a held entry
    step(0, 1, 4'd4, 16'h4444, 1, 4'd2, 16'h2222, 4'd2, 0);
    step(0, 1, 4'd2, 16'h5555, 0, 0, 0, 4'd2, 0);
    chk("squash_wl", 64'(wordline), 64'h0004);
    chk("squash_data", 64'(wr_data_q), 64'h5555);
    chk("squash_coll", 64'(collision), 64'h1);
    idle(4'd2);
    chk("squash_single", 64'(wordline), 64'h0);

    // Counter saturation
    for (int i = 0; i < 300; i++)
      step(0, 1, 4'd6, 16'(i), 1, 4'd6, 16'hFFFF, 4'd6, 0);
    chk("sat_cnt", 64'(coll_cnt), 64'd255);
    chk("sat_coll", 64'(collision), 64'h1);
    idle(0);

    // Address 0 behaviour
    step(0, 1, 4'd0, 16'h0F0F, 0, 0, 0, 4'd0, 0);
    chk("zero_wl", 64'(wordline), ZR ? 64'h0 : 64'h0001);
    idle(0);

    // Reset mid-operation discards stage and hold
    step(0, 1, 4'd1, 16'h0101, 1, 4'd6, 16'h0606, 4'd6, 4'd1);
    step(1, 0, 0, 0, 0, 0, 0, 4'd6, 4'd1);
    chk("midrst_wl", 64'(wordline), 64'h0);
    idle(4'd6);
    chk("midrst_no_hold", 64'(wordline), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      logic [3:0] aa = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      logic [3:0] ab = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, aa, 16'($urandom),
           $urandom_range(0, 2) != 0, ab, 16'($urandom),
           narrow ? 4'($urandom_range(0, 3)) : 4'($urandom), 4'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
